// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side framer and its skid buffer.
package fifo_rd_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } frame_state_e;

    localparam int DEF_WIDTH  = 9;
    localparam int SKID_DEPTH = 2;
    localparam int OCC_W      = $clog2(SKID_DEPTH + 1);

    typedef logic [OCC_W-1:0] occ_t;

    // The EOP marker always rides in the top bit of a FIFO word.
    function automatic int eop_bit(input int width);
        return width - 1;
    endfunction

    localparam int EOP_BIT = eop_bit(DEF_WIDTH);

endpackage

// File: rtl/fifo_rd_framer_if.sv
// FIFO read port plus framed valid/ready output stream of the read-side framer.
interface fifo_rd_framer_if #(
    parameter int WIDTH = 9,
    parameter int PTR   = 4
);
    logic             fifo_rden;
    logic [WIDTH-1:0] fifo_dataout;
    logic             fifo_rdempty;
    logic [PTR:0]     fifo_rdusedw;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-2:0] out_data;
    logic             out_sop;
    logic             out_eop;
    logic             out_err;

    modport master (
        output fifo_rden,
        input  fifo_dataout,
        input  fifo_rdempty,
        input  fifo_rdusedw,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_sop,
        output out_eop,
        output out_err
    );

    modport slave (
        input  fifo_rden,
        output fifo_dataout,
        output fifo_rdempty,
        output fifo_rdusedw,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_sop,
        input  out_eop,
        input  out_err
    );

endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry in-order skid buffer that absorbs the FIFO's registered read latency.
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             ready,
    output logic [WIDTH-1:0] head,
    output occ_t             occ,
    output logic             pop
);

    logic [WIDTH-1:0] tail;

    assign pop = (occ != occ_t'(0)) && ready;

    // Upstream request throttling guarantees a push never lands on a full buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == occ_t'(0)) head <= push_data;
                    else                  tail <= push_data;
                    occ <= occ + occ_t'(1);
                end
                2'b01: begin
                    head <= tail;
                    occ  <= occ - occ_t'(1);
                end
                2'b11: begin
                    if (occ == occ_t'(1)) begin
                        head <= push_data;
                    end else begin
                        head <= tail;
                        tail <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_framer.sv
// Drains the async FIFO read side into a SOP/EOP framed stream with MAX_LEN truncation.
// Optional statistics outputs are enabled by defining FIFO_RD_FRAMER_STATS_EN.
//
//   state    | meaning
//   IDLE     | next popped word opens a frame (SOP)
//   IN_FRAME | at least one word of the current frame has been popped
module fifo_rd_framer
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH   = 9,
    parameter int PTR     = 4,
    parameter int MAX_LEN = 2048,
    parameter int LEN_W   = 12
) (
    input  logic             clk,
    input  logic             reset,
    fifo_rd_framer_if.master bus
`ifdef FIFO_RD_FRAMER_STATS_EN
    ,
    output logic [15:0]      frame_cnt,
    output logic [15:0]      err_cnt,
    output logic [PTR:0]     peak_usedw
`endif
);

    localparam int EOPB = eop_bit(WIDTH);

    frame_state_e     state, state_nxt;
    logic [LEN_W-1:0] len, len_nxt;

    occ_t             occ;
    logic             pop;
    logic             rd_pend;
    logic [WIDTH-1:0] head;
    logic [OCC_W:0]   fill_nxt;
    logic             rden_raw;
    logic             valid;
    logic             eop_raw;
    logic             force_eop;

    fifo_rd_skid #(.WIDTH(WIDTH)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (rd_pend),
        .push_data (bus.fifo_dataout),
        .ready     (bus.out_ready),
        .head      (head),
        .occ       (occ),
        .pop       (pop)
    );

    // Words buffered plus the read in flight, as they will stand after this edge.
    assign fill_nxt = {1'b0, occ} + (OCC_W+1)'(rd_pend) - (OCC_W+1)'(pop);
    assign rden_raw = !bus.fifo_rdempty && (fill_nxt < (OCC_W+1)'(SKID_DEPTH));
    assign bus.fifo_rden = rden_raw && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rd_pend <= 1'b0;
        else       rd_pend <= bus.fifo_rden;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            len   <= '0;
        end else begin
            state <= state_nxt;
            len   <= len_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        len_nxt   = len;
        if (pop) begin
            if (bus.out_eop) begin
                state_nxt = IDLE;
                len_nxt   = '0;
            end else begin
                state_nxt = IN_FRAME;
                len_nxt   = len + LEN_W'(1);
            end
        end
    end

    always_comb begin
        valid     = (occ != occ_t'(0));
        eop_raw   = head[EOPB];
        force_eop = valid && !eop_raw && (len == LEN_W'(MAX_LEN - 1));

        bus.out_valid = valid;
        bus.out_data  = head[WIDTH-2:0];
        bus.out_sop   = valid && (state == IDLE);
        bus.out_eop   = valid && (eop_raw || force_eop);
        bus.out_err   = force_eop;
    end

`ifdef FIFO_RD_FRAMER_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt  <= '0;
            err_cnt    <= '0;
            peak_usedw <= '0;
        end else begin
            if (pop && bus.out_eop && frame_cnt != 16'hFFFF)
                frame_cnt <= frame_cnt + 16'd1;
            if (pop && force_eop && err_cnt != 16'hFFFF)
                err_cnt <= err_cnt + 16'd1;
            if (bus.fifo_rdusedw > peak_usedw)
                peak_usedw <= bus.fifo_rdusedw;
        end
    end
`else
    logic [PTR:0] unused_usedw;
    assign unused_usedw = bus.fifo_rdusedw;
`endif

endmodule
